// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, instruction-memory request handshake,
// IF/ID pipeline register, stall hold buffer and redirect (branch/jump) handling.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_IFWrite,
  input  logic        Z,
  input  logic        J,
  input  logic        JR,
  input  logic [31:0] BranchAddr,
  input  logic [31:0] JumpAddr,
  input  logic [31:0] JrAddr,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [31:0] Instruction_id,
  output logic [31:0] NextPC_id,
  output logic        Valid_id
);

  // REQ: request outstanding at PC. HOLD: word captured during a stall.
  // DROP: redirect seen before the ack; finish the old request, then jump.
  typedef enum logic [1:0] {S_REQ, S_HOLD, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] target_q, target_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] nextpc_q, nextpc_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic [31:0] redirect_addr;
  logic [31:0] pc_plus4;

  // Redirects only count when decode is not stalling; JR beats J beats Z.
  assign redirect      = PC_IFWrite & (JR | J | Z);
  assign redirect_addr = JR ? JrAddr : (J ? JumpAddr : BranchAddr);
  assign pc_plus4      = pc_q + 32'd4;

  // Memory request is a pure function of state and PC; forced low in reset.
  assign IMemReq        = rst_n & (state_q != S_HOLD);
  assign IMemAddr       = pc_q;
  assign Instruction_id = instr_q;
  assign NextPC_id      = nextpc_q;
  assign Valid_id       = valid_q;

  // Next-state and register-update decisions for the fetch handshake.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    buf_d    = buf_q;
    target_d = target_q;
    instr_d  = instr_q;
    nextpc_d = nextpc_q;
    valid_d  = valid_q;
    case (state_q)
      S_REQ: begin
        if (IMemAck) begin
          if (!PC_IFWrite) begin
            // Decode stalled: park the word until the pipeline can take it.
            buf_d   = IMemData;
            state_d = S_HOLD;
          end else if (redirect) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            pc_d    = redirect_addr;
          end else begin
            instr_d  = IMemData;
            nextpc_d = pc_plus4;
            valid_d  = 1'b1;
            pc_d     = pc_plus4;
          end
        end else if (PC_IFWrite) begin
          // No word yet: insert a bubble; a redirect must wait for the ack.
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          if (redirect) begin
            target_d = redirect_addr;
            state_d  = S_DROP;
          end
        end
      end
      S_HOLD: begin
        if (PC_IFWrite) begin
          state_d = S_REQ;
          if (redirect) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            pc_d    = redirect_addr;
          end else begin
            instr_d  = buf_q;
            nextpc_d = pc_plus4;
            valid_d  = 1'b1;
            pc_d     = pc_plus4;
          end
        end
      end
      S_DROP: begin
        if (PC_IFWrite) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
        if (IMemAck) begin
          pc_d    = target_q;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      buf_q    <= 32'h0;
      target_q <= 32'h0;
      instr_q  <= NOP_INSTR;
      nextpc_q <= 32'h0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      buf_q    <= buf_d;
      target_q <= target_d;
      instr_q  <= instr_d;
      nextpc_q <= nextpc_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a combinational instruction memory.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        PC_IFWrite;
  logic        Z, J, JR;
  logic [31:0] BranchAddr, JumpAddr, JrAddr;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemData;
  logic [31:0] Instruction_id;
  logic [31:0] NextPC_id;
  logic        Valid_id;

  int passed = 0;
  int total  = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .PC_IFWrite(PC_IFWrite),
    .Z(Z), .J(J), .JR(JR),
    .BranchAddr(BranchAddr), .JumpAddr(JumpAddr), .JrAddr(JrAddr),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck), .IMemData(IMemData),
    .Instruction_id(Instruction_id), .NextPC_id(NextPC_id), .Valid_id(Valid_id)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign IMemData = word(IMemAddr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] npc,
                          input logic vld);
    chk({tag, "_instr"}, Instruction_id, ins);
    chk({tag, "_npc"}, NextPC_id, npc);
    chk({tag, "_valid"}, {31'h0, Valid_id}, {31'h0, vld});
  endtask

  initial begin
    rst_n = 1'b0; PC_IFWrite = 1'b1; Z = 0; J = 0; JR = 0; IMemAck = 0;
    BranchAddr = 0; JumpAddr = 0; JrAddr = 0;
    #12;
    chk("rst_req", {31'h0, IMemReq}, 32'h0);
    chk_ifid("rst", NOP, 32'h0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("first_req", {31'h0, IMemReq}, 32'h1);
    chk("first_addr", IMemAddr, 32'h0);

    // Zero-wait streaming fetch: 0,4,8,C.
    IMemAck = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("stream_addr", IMemAddr, 32'(4 * k));
      chk_ifid("stream", word(32'(4 * (k - 1))), 32'(4 * k), 1'b1);
    end

    // Late ack at 0x10: two bubbles then the word.
    IMemAck = 1'b0;
    step(); chk_ifid("wait1", NOP, 32'h10, 1'b0); chk("wait1_addr", IMemAddr, 32'h10);
    step(); chk_ifid("wait2", NOP, 32'h10, 1'b0); chk("wait2_addr", IMemAddr, 32'h10);
    IMemAck = 1'b1;
    step(); chk_ifid("late", word(32'h10), 32'h14, 1'b1); chk("late_addr", IMemAddr, 32'h14);
    step(); step(); step();
    chk("at20", IMemAddr, 32'h20);
    chk_ifid("pre_hold", word(32'h1C), 32'h20, 1'b1);

    // Ack at 0x20 during a stall -> HOLD.
    PC_IFWrite = 1'b0;
    step();
    IMemAck = 1'b0;
    chk("hold_req", {31'h0, IMemReq}, 32'h0);
    chk_ifid("hold1", word(32'h1C), 32'h20, 1'b1);
    step();
    chk("hold2_req", {31'h0, IMemReq}, 32'h0);
    chk_ifid("hold2", word(32'h1C), 32'h20, 1'b1);
    PC_IFWrite = 1'b1;
    step();
    chk_ifid("unhold", word(32'h20), 32'h24, 1'b1);
    chk("unhold_req", {31'h0, IMemReq}, 32'h1);
    chk("unhold_addr", IMemAddr, 32'h24);

    // Stream up to 0x40.
    IMemAck = 1'b1;
    for (int k = 0; k < 7; k++) step();
    chk("at40", IMemAddr, 32'h40);

    // Branch while 0x40 is unacked -> DROP.
    IMemAck = 1'b0; Z = 1'b1; BranchAddr = 32'h100;
    step();
    Z = 1'b0;
    chk("drop_addr", IMemAddr, 32'h40);
    chk("drop_req", {31'h0, IMemReq}, 32'h1);
    chk_ifid("drop", NOP, 32'h40, 1'b0);
    J = 1'b1; JumpAddr = 32'h0000_9990;   // ignored in DROP
    step();
    J = 1'b0;
    chk("drop2_addr", IMemAddr, 32'h40);
    IMemAck = 1'b1;
    step();
    chk("drop_done_addr", IMemAddr, 32'h100);
    chk_ifid("drop_done", NOP, 32'h40, 1'b0);
    step();
    chk_ifid("tgt", word(32'h100), 32'h104, 1'b1);

    // J and Z together with same-cycle ack: J wins.
    J = 1'b1; Z = 1'b1; JumpAddr = 32'h200; BranchAddr = 32'h300;
    step();
    chk_ifid("jz", NOP, 32'h104, 1'b0);
    chk("jz_addr", IMemAddr, 32'h200);
    // JR beats J.
    JR = 1'b1; JrAddr = 32'h400;
    step();
    JR = 1'b0; J = 1'b0; Z = 1'b0;
    chk("jr_addr", IMemAddr, 32'h400);
    step();
    chk_ifid("jr_tgt", word(32'h400), 32'h404, 1'b1);

    // Redirect with stall and no ack is ignored.
    IMemAck = 1'b0; PC_IFWrite = 1'b0; Z = 1'b1; BranchAddr = 32'h500;
    step();
    Z = 1'b0;
    chk("stall_ign_addr", IMemAddr, 32'h404);
    chk_ifid("stall_ign", word(32'h400), 32'h404, 1'b1);

    // HOLD then redirect to 0xFFFFFFFC; PC+4 wraps to 0.
    IMemAck = 1'b1;
    step();
    IMemAck = 1'b0;
    chk("hold3_req", {31'h0, IMemReq}, 32'h0);
    PC_IFWrite = 1'b1; J = 1'b1; JumpAddr = 32'hFFFF_FFFC;
    step();
    J = 1'b0;
    chk_ifid("hold_redir", NOP, 32'h404, 1'b0);
    chk("hold_redir_addr", IMemAddr, 32'hFFFF_FFFC);
    IMemAck = 1'b1;
    step();
    chk_ifid("wrap", word(32'hFFFF_FFFC), 32'h0, 1'b1);
    chk("wrap_addr", IMemAddr, 32'h0);

    // Reset asserted mid-HOLD acts immediately.
    PC_IFWrite = 1'b0;
    step();
    IMemAck = 1'b0;
    chk("hold4_req", {31'h0, IMemReq}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'h0, IMemReq}, 32'h0);
    chk_ifid("arst", NOP, 32'h0, 1'b0);
    step();
    #2 rst_n = 1'b1; PC_IFWrite = 1'b1;
    #1;
    chk("rel_req", {31'h0, IMemReq}, 32'h1);
    chk("rel_addr", IMemAddr, 32'h0);
    IMemAck = 1'b1;
    step();
    chk_ifid("rel_fetch", word(32'h0), 32'h4, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded at reset.
REQ-002 Parameter NOP_INSTR, 32'h0000_0000, instruction word written into IF/ID for bubbles and flushes.
REQ-003 Ports (name  direction  width  meaning):
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- PC_IFWrite  input  1  0 = hold PC and IF/ID (load-use stall from decode).
- Z  input  1  conditional branch taken (resolved in decode).
- J  input  1  jump.
- JR  input  1  jump register.
- BranchAddr  input  32  branch target.
- JumpAddr  input  32  jump target.
- JrAddr  input  32  jump-register target.
- IMemReq  output  1  instruction-memory request.
- IMemAddr  output  32  request address; stable while IMemReq=1 and no ack.
- IMemAck  input  1  one-cycle ack; IMemData valid in the same cycle.
- IMemData  input  32  fetched word.
- Instruction_id  output  32  IF/ID instruction register.
- NextPC_id  output  32  IF/ID PC+4 register.
- Valid_id  output  1  IF/ID holds a real instruction.

Function
REQ-004 States SHALL be REQ, HOLD, DROP; 32-bit PC register, 32-bit hold buffer, 32-bit TargetPC register.
REQ-005 Redirect SHALL be active when PC_IFWrite=1 and (JR|J|Z); target priority JR>J>Z (JrAddr, JumpAddr, BranchAddr); redirects with PC_IFWrite=0 are ignored.
REQ-006 PC+4 SHALL be computed modulo 2^32 (32'hFFFF_FFFC+4=0).
REQ-007 REQ: IMemReq=1, IMemAddr=PC; ack may arrive the same cycle (zero-wait), giving one fetch per cycle.
REQ-008 REQ, ack, PC_IFWrite=1, no redirect: Instruction_id<=IMemData, NextPC_id<=PC+4, Valid_id<=1, PC<=PC+4.
REQ-009 REQ, ack, redirect: IF/ID<=NOP_INSTR/Valid_id=0 (NextPC_id held), PC<=target, stay REQ; fetched word discarded.
REQ-010 REQ, ack, PC_IFWrite=0: buffer<=IMemData, go HOLD; PC and IF/ID unchanged.
REQ-011 REQ, no ack, PC_IFWrite=1, no redirect: IF/ID<=NOP_INSTR, Valid_id<=0 (bubble); PC unchanged.
REQ-012 REQ, no ack, redirect: IF/ID<=NOP, TargetPC<=target, go DROP; PC and IMemAddr unchanged.
REQ-013 REQ/DROP, no ack, PC_IFWrite=0: all registers hold.
REQ-014 HOLD: IMemReq=0; on PC_IFWrite=1 with no redirect: IF/ID<=buffer, NextPC_id<=PC+4, Valid_id<=1, PC<=PC+4, go REQ; with redirect: IF/ID<=NOP, PC<=target, discard buffer, go REQ.
REQ-015 DROP: IMemReq=1, IMemAddr=PC (old); IF/ID<=NOP when PC_IFWrite=1; on ack: discard data, PC<=TargetPC, go REQ; further redirects ignored.
REQ-016 All register updates SHALL occur on rising clk only; IMemReq/IMemAddr are combinational from state and PC.

Reset
REQ-017 rst_n=0 SHALL immediately force: state REQ, PC=RESET_PC, Instruction_id=NOP_INSTR, NextPC_id=0, Valid_id=0, buffer=0, TargetPC=0, IMemReq=0.
REQ-018 Reset asserted mid-request SHALL abandon it; first request after deassertion SHALL address RESET_PC.

Verification
REQ-019 Zero-wait memory, ack every cycle, PC_IFWrite=1 -> addresses 0,4,8,...; Instruction_id follows words with one-cycle latency, NextPC_id=addr+4.
REQ-020 Ack 3 cycles after request at PC=0x10 -> two NOP bubbles (Valid_id=0), then word at 0x10 with NextPC_id=0x14.
REQ-021 Ack at PC=0x20 with PC_IFWrite=0 for 2 cycles -> HOLD, IMemReq=0, IF/ID unchanged; PC_IFWrite=1 -> buffered word in IF/ID, next request 0x24.
REQ-022 Z=1, BranchAddr=0x100 while request to 0x40 unacked -> DROP, IMemAddr stays 0x40; on ack word discarded, next IMemAddr=0x100.
REQ-023 J=1 and Z=1 simultaneously, JumpAddr=0x200, BranchAddr=0x300, ack same cycle -> IF/ID=NOP, next IMemAddr=0x200.
REQ-024 rst_n low mid-HOLD -> outputs at reset values asynchronously; after release first IMemAddr=RESET_PC.
